fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: owns the PC, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register.
- Consumes the load-use stall from hazard detection: on stall it freezes PC and IF/ID.
- Consumes the branch flush from ID: on flush it redirects the PC and inserts a bubble.
- A 1-entry skid buffer holds an instruction that returns while the pipeline is stalled, so no fetched instruction is lost or duplicated.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID for a bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  load-use stall from hazard detection; freezes PC and IF/ID.
- flush_i  in  1  branch taken, resolved in ID; valid only when stall_i=0.
- branch_target_i  in  32  redirect PC; bits [1:0] are forced to 0.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch word address; stable while imem_req_o=1 and not acked.
- imem_ack_i  in  1  in a cycle with imem_req_o=1, imem_rdata_i is valid and the transfer completes at that edge.
- imem_rdata_i  in  32  fetched instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  32  PC of the IF/ID instruction.
- ifid_instr_o  out  32  IF/ID instruction (NOP_INSTR when invalid).

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- State is held in registers: state (FETCH, HOLD, DRAIN), pc_q, redirect_q, skid_pc, skid_instr.
- Reset values:
  - state=FETCH, pc_q=RESET_PC.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR.
  - Skid buffer empty.
  - imem_req_o=0 while rst_i=1.
  - Reset asserted in any state, including mid-DRAIN, abandons the outstanding request without waiting for ack.
- Decoded outputs:
  - imem_req_o = (state==FETCH or DRAIN) and !rst_i.
  - imem_addr_o = pc_q.
- Effective flush: fl = flush_i & !stall_i. When stall_i=1, flush_i is ignored.
- FETCH:
  - fl & ack: IF/ID <- bubble; pc_q <- target; stay FETCH; the new address is presented next cycle.
  - fl & !ack: IF/ID <- bubble; redirect_q <- target; go to DRAIN. The request stays on the old pc_q.
  - !fl & ack & !stall: IF/ID <- {1, pc_q, rdata}; pc_q <- pc_q+4.
  - ack & stall: IF/ID holds; skid <- {pc_q, rdata}; pc_q <- pc_q+4; go to HOLD.
  - !ack & !stall & !fl: IF/ID <- bubble.
  - !ack & stall: everything holds.
- HOLD (imem_req_o=0):
  - stall: hold.
  - fl: discard skid; IF/ID <- bubble; pc_q <- target; go to FETCH.
  - otherwise: IF/ID <- {1, skid_pc, skid_instr}; go to FETCH.
- DRAIN (request outstanding, data will be discarded):
  - IF/ID <- bubble each cycle unless stall (stall holds IF/ID).
  - fl: redirect_q <- new target.
  - ack: data dropped; pc_q <- redirect_q, or the new target if fl in the same cycle; go to FETCH.
- PC arithmetic: 32-bit, wraps from 0xFFFF_FFFC to 0x0000_0000.
- Throughput and latency:
  - With ack tied high, one instruction per cycle.
  - An instruction acked in cycle n appears in IF/ID in cycle n+1.
- Invariants for the verifier:
  - Every acked instruction not cancelled by flush or reset reaches IF/ID exactly once.
  - The sequence of ifid_valid_o PCs is program order.

Test Plan:
1. Reset, then ack tied 1, no stall/flush: imem_addr_o = 0, 4, 8, … on consecutive cycles; ifid_pc_o 0, 4, 8 one cycle later with ifid_valid_o=1; ifid_valid_o=0 and ifid_instr_o=0x13 during reset.
2. Ack every 3rd cycle: imem_addr_o stays stable until ack; IF/ID shows 2 bubbles (valid=0, instr=0x13) between instructions.
3. Stall_i=1 for 3 cycles with ack during the first stall cycle (pc=8):
   - state HOLD; imem_req_o=0; IF/ID unchanged.
   - After release, IF/ID shows pc 8 next, then fetch resumes at 12.
   - No gap or duplicate.
4. Flush_i=1 with target 0x102 while fetch of 0x10 is unacked (ack 2 cycles later):
   - DRAIN; 0x10 data never appears in IF/ID.
   - Next request address is 0x100; IF/ID bubbles until then.
5. Flush_i=1 and stall_i=1 in the same cycle: flush ignored; PC and IF/ID held; a fetch acked in that cycle goes to the skid buffer and is delivered normally after release.
6. Reset asserted during DRAIN and HOLD: the next cycle shows state FETCH, imem_addr_o=RESET_PC, ifid_valid_o=0; a late ack during reset is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over imem req/ack and drives IF/ID.
// A one-entry skid buffer catches an instruction that returns while ID is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer completes at a rising edge where imem_req_o=1 and
    // imem_ack_i=1; imem_addr_o stays stable from request until that edge.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] redirect_q, redirect_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic        valid_q, valid_n;
    logic [31:0] ifid_pc_q, ifid_pc_n;
    logic [31:0] ifid_instr_q, ifid_instr_n;
    logic        fl;
    logic [31:0] target;

    assign fl     = flush_i & ~stall_i;
    assign target = {branch_target_i[31:2], 2'b00};

    assign imem_req_o   = ((state == FETCH) || (state == DRAIN)) && !rst_i;
    assign imem_addr_o  = pc_q;
    assign ifid_valid_o = valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign dbg_state    = state;

    always_comb begin
        state_n      = state;
        pc_n         = pc_q;
        redirect_n   = redirect_q;
        skid_pc_n    = skid_pc;
        skid_instr_n = skid_instr;
        valid_n      = valid_q;
        ifid_pc_n    = ifid_pc_q;
        ifid_instr_n = ifid_instr_q;
        case (state)
            FETCH: begin
                if (fl) begin
                    valid_n      = 1'b0;
                    ifid_pc_n    = 32'h0;
                    ifid_instr_n = NOP_INSTR;
                    if (imem_ack_i) begin
                        pc_n = target;
                    end else begin
                        redirect_n = target;
                        state_n    = DRAIN;
                    end
                end else if (imem_ack_i) begin
                    pc_n = pc_q + 32'd4;
                    if (stall_i) begin
                        skid_pc_n    = pc_q;
                        skid_instr_n = imem_rdata_i;
                        state_n      = HOLD;
                    end else begin
                        valid_n      = 1'b1;
                        ifid_pc_n    = pc_q;
                        ifid_instr_n = imem_rdata_i;
                    end
                end else if (!stall_i) begin
                    valid_n      = 1'b0;
                    ifid_pc_n    = 32'h0;
                    ifid_instr_n = NOP_INSTR;
                end
            end
            HOLD: begin
                if (fl) begin
                    // The skidded instruction is on the wrong path; drop it.
                    valid_n      = 1'b0;
                    ifid_pc_n    = 32'h0;
                    ifid_instr_n = NOP_INSTR;
                    pc_n         = target;
                    state_n      = FETCH;
                end else if (!stall_i) begin
                    valid_n      = 1'b1;
                    ifid_pc_n    = skid_pc;
                    ifid_instr_n = skid_instr;
                    state_n      = FETCH;
                end
            end
            DRAIN: begin
                if (!stall_i) begin
                    valid_n      = 1'b0;
                    ifid_pc_n    = 32'h0;
                    ifid_instr_n = NOP_INSTR;
                end
                if (fl) begin
                    redirect_n = target;
                end
                if (imem_ack_i) begin
                    pc_n    = fl ? target : redirect_q;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= FETCH;
            pc_q         <= RESET_PC;
            redirect_q   <= RESET_PC;
            skid_pc      <= 32'h0;
            skid_instr   <= NOP_INSTR;
            valid_q      <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state        <= state_n;
            pc_q         <= pc_n;
            redirect_q   <= redirect_n;
            skid_pc      <= skid_pc_n;
            skid_instr   <= skid_instr_n;
            valid_q      <= valid_n;
            ifid_pc_q    <= ifid_pc_n;
            ifid_instr_q <= ifid_instr_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, slow memory, stall/skid, flush/drain,
// flush under stall, reset mid-transaction and PC wraparound.
module tb_fetch_stage;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .ifid_valid_o    (ifid_valid_o),
        .ifid_pc_o       (ifid_pc_o),
        .ifid_instr_o    (ifid_instr_o),
        .dbg_state       (dbg_state)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // Memory content: each word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    assign imem_rdata_i = mem_word(imem_addr_o);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'd1);
        check({tag, "_pc"}, ifid_pc_o, pc);
        check({tag, "_instr"}, ifid_instr_o, mem_word(pc));
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_valid"}, {31'b0, ifid_valid_o}, 32'd0);
        check({tag, "_instr"}, ifid_instr_o, NOP);
    endtask

    initial begin
        rst_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        branch_target_i = 32'h0;
        imem_ack_i = 1'b1;

        // 1: reset, then streaming with ack tied high
        step();
        step();
        check_bubble("rst");
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_state", {30'b0, dbg_state}, {30'b0, S_FETCH});
        rst_i = 1'b0;
        #1;
        check("first_req", {31'b0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_ifid("stream", 32'(4 * (i - 1)));
            check("stream_addr", imem_addr_o, 32'(4 * i));
        end

        // 2: ack every third cycle
        for (int r = 0; r < 2; r++) begin
            imem_ack_i = 1'b0;
            for (int k = 0; k < 2; k++) begin
                step();
                check_bubble("slow_bub");
                check("slow_addr_hold", imem_addr_o, 32'(16 + 4 * r));
            end
            imem_ack_i = 1'b1;
            step();
            check_ifid("slow", 32'(16 + 4 * r));
            check("slow_addr_next", imem_addr_o, 32'(20 + 4 * r));
        end

        // 3: three stall cycles, ack on the first one lands in the skid
        stall_i = 1'b1;
        step();
        check("hold_state", {30'b0, dbg_state}, {30'b0, S_HOLD});
        check("hold_req", {31'b0, imem_req_o}, 32'd0);
        check_ifid("hold_freeze", 32'd20);
        imem_ack_i = 1'b0;
        step();
        step();
        check("hold_state2", {30'b0, dbg_state}, {30'b0, S_HOLD});
        check_ifid("hold_freeze2", 32'd20);
        stall_i = 1'b0;
        imem_ack_i = 1'b1;
        step();
        check_ifid("skid_out", 32'd24);
        check("skid_addr", imem_addr_o, 32'd28);
        step();
        check_ifid("after_skid", 32'd28);

        // 4: flush with the current fetch unacked -> DRAIN, then redirect
        imem_ack_i = 1'b0;
        flush_i = 1'b1;
        branch_target_i = 32'h0000_0102;
        step();
        check("drain_state", {30'b0, dbg_state}, {30'b0, S_DRAIN});
        check("drain_addr", imem_addr_o, 32'd32);
        check("drain_req", {31'b0, imem_req_o}, 32'd1);
        check_bubble("drain_bub");
        flush_i = 1'b0;
        step();
        check_bubble("drain_bub2");
        imem_ack_i = 1'b1;
        step();
        check_bubble("drain_drop");
        check("redirect_addr", imem_addr_o, 32'h100);
        check("redirect_state", {30'b0, dbg_state}, {30'b0, S_FETCH});
        step();
        check_ifid("redirect", 32'h100);

        // 5: flush together with stall is ignored; the acked fetch goes through the skid
        stall_i = 1'b1;
        flush_i = 1'b1;
        branch_target_i = 32'h0000_0200;
        step();
        check("fs_state", {30'b0, dbg_state}, {30'b0, S_HOLD});
        check_ifid("fs_freeze", 32'h100);
        check("fs_addr", imem_addr_o, 32'h108);
        stall_i = 1'b0;
        flush_i = 1'b0;
        step();
        check_ifid("fs_skid", 32'h104);
        step();
        check_ifid("fs_next", 32'h108);

        // flush while holding a skidded instruction discards it
        stall_i = 1'b1;
        step();
        stall_i = 1'b0;
        flush_i = 1'b1;
        branch_target_i = 32'h0000_0300;
        step();
        check_bubble("hold_flush");
        check("hold_flush_addr", imem_addr_o, 32'h300);
        flush_i = 1'b0;
        step();
        check_ifid("hold_flush_tgt", 32'h300);

        // second flush during DRAIN, coinciding with the ack, wins
        imem_ack_i = 1'b0;
        flush_i = 1'b1;
        branch_target_i = 32'h0000_0400;
        step();
        branch_target_i = 32'h0000_0501;
        imem_ack_i = 1'b1;
        step();
        check("drain_reflush_addr", imem_addr_o, 32'h500);
        check_bubble("drain_reflush");
        flush_i = 1'b0;
        step();
        check_ifid("drain_reflush_tgt", 32'h500);

        // 6: reset during DRAIN with a late ack
        imem_ack_i = 1'b0;
        flush_i = 1'b1;
        branch_target_i = 32'h0000_0600;
        step();
        check("pre_rst_drain", {30'b0, dbg_state}, {30'b0, S_DRAIN});
        flush_i = 1'b0;
        rst_i = 1'b1;
        imem_ack_i = 1'b1;
        step();
        check("rst_drain_state", {30'b0, dbg_state}, {30'b0, S_FETCH});
        check("rst_drain_addr", imem_addr_o, 32'h0);
        check("rst_drain_req", {31'b0, imem_req_o}, 32'd0);
        check_bubble("rst_drain");
        rst_i = 1'b0;
        step();
        check_ifid("rst_drain_resume", 32'h0);

        // reset during HOLD
        stall_i = 1'b1;
        step();
        check("pre_rst_hold", {30'b0, dbg_state}, {30'b0, S_HOLD});
        stall_i = 1'b0;
        rst_i = 1'b1;
        step();
        check("rst_hold_state", {30'b0, dbg_state}, {30'b0, S_FETCH});
        check("rst_hold_addr", imem_addr_o, 32'h0);
        check_bubble("rst_hold");
        rst_i = 1'b0;
        step();
        check_ifid("rst_hold_resume", 32'h0);

        // PC wraps from 0xFFFF_FFFC to 0
        flush_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        step();
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        flush_i = 1'b0;
        step();
        check_ifid("wrap_top", 32'hFFFF_FFFC);
        check("wrap_addr0", imem_addr_o, 32'h0);
        step();
        check_ifid("wrap_zero", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
